// File: rtl/mem_share_ctrl_if.sv
// Bus bundle for mem_share_ctrl: UART-side access port, processor port and shared BRAM port.
// slave = controller side, master = surrounding system (UART, processor, BRAM).
interface mem_share_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              io_req;
  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_ack;
  logic [DATA_W-1:0] io_rdata;

  logic [ADDR_W-1:0] pro_addr;
  logic [DATA_W-1:0] pro_wdata;
  logic              pro_we;
  logic [DATA_W-1:0] pro_rdata;
  logic              pro_en;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output io_req, io_we, io_addr, io_wdata,
    output pro_addr, pro_wdata, pro_we,
    output mem_rdata,
    input  io_ack, io_rdata, pro_rdata, pro_en,
    input  mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  io_req, io_we, io_addr, io_wdata,
    input  pro_addr, pro_wdata, pro_we,
    input  mem_rdata,
    output io_ack, io_rdata, pro_rdata, pro_en,
    output mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_share_ctrl.sv
// Mode FSM arbitrating one BRAM port between a UART loader and a processor.
// Optional macro MSC_DEBUG_READ_EN: io reads in RUN steal single processor cycles.
//
// state  | meaning
// IDLE   | no mode selected, io side owns the port (reads only)
// LOAD   | io side owns the port, writes allowed
// RUN    | processor clocked and owns the port
// SEND   | io side owns the port (reads only)
// HALTED | processor finished, io side owns the port (reads only)
module mem_share_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic           clk_100,
  input  logic           rst,
  input  logic [2:0]     ctrlSw,
  input  logic           halt,
  mem_share_ctrl_if.slave bus,
  output logic [2:0]     ledInd,
  output logic [2:0]     state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic [2:0]        state_q;
  logic [2:0]        state_nxt;
  logic [2:0]        req_mode;
  logic              ack_q;
  logic              accept;
  logic              io_write;
  logic              pro_en_c;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_mux;

  always_comb begin
    req_mode = S_IDLE;
    case (ctrlSw)
      3'b001:  req_mode = S_LOAD;
      3'b010:  req_mode = S_RUN;
      3'b100:  req_mode = S_SEND;
      default: req_mode = S_IDLE;
    endcase
  end

  always_comb begin
    state_nxt = req_mode;
    case (state_q)
      S_RUN:    state_nxt = halt ? S_HALTED : req_mode;
      S_HALTED: state_nxt = (req_mode == S_RUN) ? S_HALTED : req_mode;
      default:  state_nxt = req_mode;
    endcase
  end

`ifdef MSC_DEBUG_READ_EN
  // A pending io request in RUN parks the processor for exactly one cycle; the
  // in-flight ack cycle blocks a second steal, so at most one steal per two clocks.
  assign pro_en_c = (state_q == S_RUN) && !rst && !(bus.io_req && !ack_q);
`else
  assign pro_en_c = (state_q == S_RUN) && !rst;
`endif

  assign accept   = bus.io_req && !ack_q && !pro_en_c && !rst;
  assign io_write = accept && bus.io_we && (state_q == S_LOAD);

  assign addr_mux      = pro_en_c ? bus.pro_addr : bus.io_addr;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = pro_en_c ? bus.pro_wdata : bus.io_wdata;
  assign bus.mem_we    = pro_en_c ? bus.pro_we : io_write;
  assign bus.pro_en    = pro_en_c;
  assign bus.pro_rdata = bus.mem_rdata;

  // BRAM data is valid in the ack cycle itself, so it is forwarded then and held after.
  assign bus.io_ack   = ack_q && !rst;
  assign bus.io_rdata = rst ? '0 : (ack_q ? bus.mem_rdata : rdata_q);

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= accept;
      if (ack_q) rdata_q <= bus.mem_rdata;
      // A mode change requested alongside an accepted access waits one cycle.
      if (!accept) state_q <= state_nxt;
    end
  end

  always_comb begin
    ledInd = 3'b000;
    case (state_q)
      S_LOAD:   ledInd = 3'b001;
      S_RUN:    ledInd = 3'b010;
      S_SEND:   ledInd = 3'b100;
      S_HALTED: ledInd = 3'b011;
      default:  ledInd = 3'b000;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mem_share_ctrl.sv
// Self-checking bench for mem_share_ctrl: BRAM model plus read-data scoreboard.
`timescale 1ns/1ps
module tb_mem_share_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_RUN = 3'd2,
                         ST_SEND = 3'd3, ST_HALTED = 3'd4;

  logic clk_100 = 1'b0;
  logic rst = 1'b1;
  logic [2:0] ctrl_sw = 3'b000;
  logic halt = 1'b0;
  logic [2:0] led_ind;
  logic [2:0] fsm_state;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] sb_exp;

  mem_share_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_share_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_100(clk_100),
    .rst(rst),
    .ctrlSw(ctrl_sw),
    .halt(halt),
    .bus(bus),
    .ledInd(led_ind),
    .state(fsm_state)
  );

  always #5 clk_100 = ~clk_100;

  // Read-first BRAM, one cycle read latency.
  always @(posedge clk_100) begin
    if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bram[bus.mem_addr];
  end

  // Scoreboard: every ack pops the value expected when its access was driven.
  always @(negedge clk_100) begin
    if (bus.io_ack === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL sb_unexpected_ack got_rdata=%h exp=no_ack", bus.io_rdata);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bus.io_rdata !== sb_exp) begin
          bad++; $display("FAIL sb_rdata got=%h exp=%h", bus.io_rdata, sb_exp);
        end
      end
    end
  end

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic step();
    @(posedge clk_100); #1;
  endtask

  task automatic io_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.io_req = 1'b1; bus.io_we = we; bus.io_addr = a; bus.io_wdata = d;
  endtask

  task automatic io_idle();
    bus.io_req = 1'b0; bus.io_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ctrl_sw = 3'b000; io_idle();
    repeat (3) step();
    @(negedge clk_100);
    total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", fsm_state, ST_IDLE); end
    total++; if (led_ind !== 3'b000) begin bad++; $display("FAIL rst_led got=%b exp=000", led_ind); end
    total++; if (bus.pro_en !== 1'b0) begin bad++; $display("FAIL rst_pro_en got=%b exp=0", bus.pro_en); end
    total++; if (bus.io_ack !== 1'b0) begin bad++; $display("FAIL rst_io_ack got=%b exp=0", bus.io_ack); end
    total++; if (bus.io_rdata !== 16'h0000) begin bad++; $display("FAIL rst_io_rdata got=%h exp=0000", bus.io_rdata); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    rst = 1'b0;
  endtask

  task automatic test_load();
    step(); ctrl_sw = 3'b001;
    step();
    @(negedge clk_100);
    total++; if (fsm_state !== ST_LOAD) begin bad++; $display("FAIL load_state got=%0d exp=%0d", fsm_state, ST_LOAD); end
    total++; if (led_ind !== 3'b001) begin bad++; $display("FAIL load_led got=%b exp=001", led_ind); end
    step(); io_drive(1'b1, 16'h0005, 16'hA5A5);
    exp_q.push_back(ref_rd(5)); ref_mem[5] = 16'hA5A5;
    @(negedge clk_100);
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL load_wr_we got=%b exp=1", bus.mem_we); end
    total++; if (bus.mem_addr !== 16'h0005) begin bad++; $display("FAIL load_wr_addr got=%h exp=0005", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 16'hA5A5) begin bad++; $display("FAIL load_wr_data got=%h exp=a5a5", bus.mem_wdata); end
    total++; if (bus.io_ack !== 1'b0) begin bad++; $display("FAIL load_early_ack got=%b exp=0", bus.io_ack); end
    step(); io_idle();
    @(negedge clk_100);
    total++; if (bus.io_ack !== 1'b1) begin bad++; $display("FAIL load_wr_ack got=%b exp=1", bus.io_ack); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL load_we_pulse got=%b exp=0", bus.mem_we); end
    step(); io_drive(1'b0, 16'h0005, 16'h0000);
    exp_q.push_back(ref_rd(5));
    @(negedge clk_100);
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL load_rd_we got=%b exp=0", bus.mem_we); end
    step(); io_idle();
    @(negedge clk_100);
    total++; if (bus.io_ack !== 1'b1) begin bad++; $display("FAIL load_rd_ack got=%b exp=1", bus.io_ack); end
    step();
    @(negedge clk_100);
    total++; if (bus.io_ack !== 1'b0) begin bad++; $display("FAIL load_ack_width got=%b exp=0", bus.io_ack); end
    total++; if (bus.io_rdata !== 16'hA5A5) begin bad++; $display("FAIL load_rdata_hold got=%h exp=a5a5", bus.io_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    step();
    // io_req held high: the second cycle of each pair is the in-flight cycle and must not re-accept.
    for (int i = 0; i < 6; i++) begin
      a = AW'(16'h0100 + i); d = DW'($urandom_range(0, 65535));
      io_drive(1'b1, a, d);
      exp_q.push_back(ref_rd(int'(a))); ref_mem[int'(a)] = d;
      @(negedge clk_100);
      total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL b2b_we got=%b exp=1 i=%0d", bus.mem_we, i); end
      step();
      @(negedge clk_100);
      total++; if (bus.io_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack got=%b exp=1 i=%0d", bus.io_ack, i); end
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL b2b_inflight_we got=%b exp=0 i=%0d", bus.mem_we, i); end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      a = AW'(16'h0100 + i);
      io_drive(1'b0, a, '0);
      exp_q.push_back(ref_rd(int'(a)));
      step();
      @(negedge clk_100);
      total++; if (bus.io_ack !== 1'b1) begin bad++; $display("FAIL b2b_rd_ack got=%b exp=1 i=%0d", bus.io_ack, i); end
      step();
    end
    io_idle();
  endtask

  task automatic test_mode_change_inflight();
    step(); ctrl_sw = 3'b010; io_drive(1'b0, 16'h0005, 16'h0000);
    exp_q.push_back(ref_rd(5));
    @(negedge clk_100);
    total++; if (fsm_state !== ST_LOAD) begin bad++; $display("FAIL mc_state_n got=%0d exp=%0d", fsm_state, ST_LOAD); end
    step(); io_idle();
    @(negedge clk_100);
    total++; if (bus.io_ack !== 1'b1) begin bad++; $display("FAIL mc_ack got=%b exp=1", bus.io_ack); end
    total++; if (fsm_state !== ST_LOAD) begin bad++; $display("FAIL mc_state_n1 got=%0d exp=%0d", fsm_state, ST_LOAD); end
    step();
    @(negedge clk_100);
    total++; if (fsm_state !== ST_RUN) begin bad++; $display("FAIL mc_state_n2 got=%0d exp=%0d", fsm_state, ST_RUN); end
    total++; if (bus.pro_en !== 1'b1) begin bad++; $display("FAIL mc_pro_en got=%b exp=1", bus.pro_en); end
  endtask

  task automatic test_run_io();
    step(); bus.pro_addr = 16'h0020; bus.pro_we = 1'b0;
`ifdef MSC_DEBUG_READ_EN
    io_drive(1'b1, 16'h0005, 16'hFFFF);
    exp_q.push_back(ref_rd(5));
    @(negedge clk_100);
    total++; if (bus.pro_en !== 1'b0) begin bad++; $display("FAIL steal_pro_en got=%b exp=0", bus.pro_en); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL steal_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.mem_addr !== 16'h0005) begin bad++; $display("FAIL steal_addr got=%h exp=0005", bus.mem_addr); end
    step(); io_idle();
    @(negedge clk_100);
    total++; if (bus.io_ack !== 1'b1) begin bad++; $display("FAIL steal_ack got=%b exp=1", bus.io_ack); end
    total++; if (bus.pro_en !== 1'b1) begin bad++; $display("FAIL steal_restore got=%b exp=1", bus.pro_en); end
    step();
    @(negedge clk_100);
    total++; if (bus.io_rdata !== 16'hA5A5) begin bad++; $display("FAIL steal_rdata got=%h exp=a5a5", bus.io_rdata); end
`else
    io_drive(1'b0, 16'h0005, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_100);
      total++; if (bus.pro_en !== 1'b1) begin bad++; $display("FAIL runio_pro_en got=%b exp=1 i=%0d", bus.pro_en, i); end
      total++; if (bus.io_ack !== 1'b0) begin bad++; $display("FAIL runio_ack got=%b exp=0 i=%0d", bus.io_ack, i); end
      total++; if (bus.mem_addr !== 16'h0020) begin bad++; $display("FAIL runio_addr got=%h exp=0020 i=%0d", bus.mem_addr, i); end
      step();
    end
    io_idle();
`endif
  endtask

  task automatic test_run_halt();
    step(); bus.pro_we = 1'b1; bus.pro_addr = 16'h0010; bus.pro_wdata = 16'h1234;
    @(negedge clk_100);
    total++; if (fsm_state !== ST_RUN) begin bad++; $display("FAIL run_state got=%0d exp=%0d", fsm_state, ST_RUN); end
    total++; if (led_ind !== 3'b010) begin bad++; $display("FAIL run_led got=%b exp=010", led_ind); end
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL run_mem_we got=%b exp=1", bus.mem_we); end
    total++; if (bus.mem_addr !== 16'h0010) begin bad++; $display("FAIL run_addr got=%h exp=0010", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 16'h1234) begin bad++; $display("FAIL run_wdata got=%h exp=1234", bus.mem_wdata); end
    ref_mem[16] = 16'h1234;
    step(); bus.pro_we = 1'b0; halt = 1'b1;
    @(negedge clk_100);
    total++; if (bus.pro_en !== 1'b1) begin bad++; $display("FAIL halt_pre_pro_en got=%b exp=1", bus.pro_en); end
    step(); halt = 1'b0;
    @(negedge clk_100);
    total++; if (fsm_state !== ST_HALTED) begin bad++; $display("FAIL halt_state got=%0d exp=%0d", fsm_state, ST_HALTED); end
    total++; if (led_ind !== 3'b011) begin bad++; $display("FAIL halt_led got=%b exp=011", led_ind); end
    total++; if (bus.pro_en !== 1'b0) begin bad++; $display("FAIL halt_pro_en got=%b exp=0", bus.pro_en); end
    step();
    @(negedge clk_100);
    total++; if (fsm_state !== ST_HALTED) begin bad++; $display("FAIL halt_hold got=%0d exp=%0d", fsm_state, ST_HALTED); end
    step(); io_drive(1'b0, 16'h0010, 16'h0000);
    exp_q.push_back(ref_rd(16));
    step(); io_idle();
    @(negedge clk_100);
    total++; if (bus.io_ack !== 1'b1) begin bad++; $display("FAIL halt_rd_ack got=%b exp=1", bus.io_ack); end
  endtask

  task automatic test_send();
    step(); ctrl_sw = 3'b100;
    step();
    @(negedge clk_100);
    total++; if (fsm_state !== ST_SEND) begin bad++; $display("FAIL send_state got=%0d exp=%0d", fsm_state, ST_SEND); end
    total++; if (led_ind !== 3'b100) begin bad++; $display("FAIL send_led got=%b exp=100", led_ind); end
    step(); io_drive(1'b1, 16'h0005, 16'h0000);
    exp_q.push_back(ref_rd(5));
    @(negedge clk_100);
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL send_we got=%b exp=0", bus.mem_we); end
    step(); io_idle();
    @(negedge clk_100);
    total++; if (bus.io_ack !== 1'b1) begin bad++; $display("FAIL send_ack got=%b exp=1", bus.io_ack); end
    total++; if (bus.io_rdata !== 16'hA5A5) begin bad++; $display("FAIL send_rdata got=%h exp=a5a5", bus.io_rdata); end
    step(); io_drive(1'b0, 16'h0005, 16'h0000);
    exp_q.push_back(ref_rd(5));
    step(); io_idle();
    @(negedge clk_100);
    total++; if (bus.io_ack !== 1'b1) begin bad++; $display("FAIL send_reread_ack got=%b exp=1", bus.io_ack); end
  endtask

  task automatic test_reset_inflight();
    step(); ctrl_sw = 3'b001;
    step(); io_drive(1'b0, 16'h0005, 16'h0000); rst = 1'b1;
    step(); io_idle();
    @(negedge clk_100);
    total++; if (bus.io_ack !== 1'b0) begin bad++; $display("FAIL rstif_ack got=%b exp=0", bus.io_ack); end
    total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL rstif_state got=%0d exp=%0d", fsm_state, ST_IDLE); end
    total++; if (bus.io_rdata !== 16'h0000) begin bad++; $display("FAIL rstif_rdata got=%h exp=0000", bus.io_rdata); end
    step(); rst = 1'b0; ctrl_sw = 3'b001;
    step(); ctrl_sw = 3'b011;
    @(negedge clk_100);
    total++; if (fsm_state !== ST_LOAD) begin bad++; $display("FAIL multi_pre got=%0d exp=%0d", fsm_state, ST_LOAD); end
    step();
    @(negedge clk_100);
    total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL multi_idle got=%0d exp=%0d", fsm_state, ST_IDLE); end
    total++; if (led_ind !== 3'b000) begin bad++; $display("FAIL multi_led got=%b exp=000", led_ind); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
    bus.io_req = 1'b0; bus.io_we = 1'b0; bus.io_addr = '0; bus.io_wdata = '0;
    bus.pro_addr = '0; bus.pro_wdata = '0; bus.pro_we = 1'b0;
    test_reset();
    test_load();
    test_back_to_back();
    test_mode_change_inflight();
    test_run_io();
    test_run_halt();
    test_send();
    test_reset_inflight();
    repeat (3) step();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_missing_acks got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
